// File: rtl/mdu_iter.sv
// Iterative RV64M multiply/divide unit: shift-add multiply, restoring divide, one bit per cycle.
// Divide-by-zero and signed-overflow divides bypass the iteration through a single-cycle path.
module mdu_iter #(
  parameter int unsigned XLEN     = 64,
  parameter bit          HAS_WORD = 1'b1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_op,
  input  logic            in_word,
  input  logic [XLEN-1:0] in_src1,
  input  logic [XLEN-1:0] in_src2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic            busy
);

  localparam bit          WordEn = HAS_WORD && (XLEN == 64);
  localparam int unsigned W2     = 2 * XLEN;

  typedef enum logic [1:0] {StIdle, StCalc, StFast, StDone} state_e;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    logic [XLEN-1:0] r;
    r       = {XLEN{v[31]}};
    r[31:0] = v;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] zext32(input logic [31:0] v);
    logic [XLEN-1:0] r;
    r       = '0;
    r[31:0] = v;
    return r;
  endfunction

  state_e          state_q, state_d;
  logic [6:0]      cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic            word_q, word_d;
  logic            neg_q, neg_d;
  logic            fdz_q, fdz_d;
  logic [W2-1:0]   a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [W2-1:0]   acc_q, acc_d;
  logic [XLEN-1:0] out_data_q, out_data_d;
  logic            out_valid_q, out_valid_d;

  // Request decode and operand preparation
  logic            word_in, s1_signed, s2_signed, neg1, neg2, div0, ovf, fast_in, neg_in;
  logic [XLEN-1:0] x1, x2, abs1, abs2, min_v;

  always_comb begin
    word_in   = WordEn && in_word && ((in_op == 3'b000) || in_op[2]);
    s1_signed = (in_op == 3'b001) || (in_op == 3'b010) || (in_op == 3'b100) || (in_op == 3'b110);
    s2_signed = (in_op == 3'b001) || (in_op == 3'b100) || (in_op == 3'b110);
    x1 = in_src1;
    x2 = in_src2;
    if (word_in) begin
      x1 = s1_signed ? sext32(in_src1[31:0]) : zext32(in_src1[31:0]);
      x2 = s2_signed ? sext32(in_src2[31:0]) : zext32(in_src2[31:0]);
    end
    neg1 = s1_signed && x1[XLEN-1];
    neg2 = s2_signed && x2[XLEN-1];
    abs1 = neg1 ? -x1 : x1;
    abs2 = neg2 ? -x2 : x2;
    min_v            = '0;
    min_v[XLEN-1]    = 1'b1;
    if (word_in) min_v = sext32(32'h8000_0000);
    div0    = (x2 == '0);
    ovf     = !in_op[0] && (x1 == min_v) && (x2 == '1);
    fast_in = in_op[2] && (div0 || ovf);
    unique case (in_op)
      3'b001, 3'b100: neg_in = neg1 ^ neg2;
      3'b010, 3'b110: neg_in = neg1;
      default:        neg_in = 1'b0;
    endcase
  end

  // One iteration step plus the signed/word fix-up applied on the last step
  logic [W2-1:0]   a_nx, acc_nx, prod;
  logic [XLEN-1:0] b_nx, dv, calc_res, fast_res;
  logic [XLEN:0]   r_sh, diff;
  logic            ge;

  always_comb begin
    r_sh   = {acc_q[XLEN-1:0], (word_q ? a_q[31] : a_q[XLEN-1])};
    diff   = r_sh - {1'b0, b_q};
    ge     = !diff[XLEN];
    b_nx   = b_q;
    acc_nx = '0;
    if (op_q[2]) begin
      acc_nx[XLEN:0] = ge ? diff : r_sh;
      a_nx           = {a_q[W2-2:0], ge};
    end else begin
      acc_nx = acc_q + (b_q[0] ? a_q : '0);
      a_nx   = a_q << 1;
      b_nx   = b_q >> 1;
    end

    prod = neg_q ? -acc_nx : acc_nx;
    dv   = op_q[1] ? acc_nx[XLEN-1:0] : a_nx[XLEN-1:0];
    dv   = neg_q ? -dv : dv;
    if (op_q[2])              calc_res = word_q ? sext32(dv[31:0]) : dv;
    else if (op_q == 3'b000)  calc_res = word_q ? sext32(prod[31:0]) : prod[XLEN-1:0];
    else                      calc_res = prod[W2-1:XLEN];

    // acc_q holds the unmodified dividend on the fast path
    if (fdz_q) fast_res = op_q[1] ? acc_q[XLEN-1:0] : '1;
    else       fast_res = op_q[1] ? '0 : acc_q[XLEN-1:0];
    if (word_q) fast_res = sext32(fast_res[31:0]);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    word_d      = word_q;
    neg_d       = neg_q;
    fdz_d       = fdz_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          cnt_d  = '0;
          op_d   = in_op;
          word_d = word_in;
          neg_d  = neg_in;
          fdz_d  = div0;
          a_d    = '0;
          a_d[XLEN-1:0] = abs1;
          b_d    = abs2;
          acc_d  = '0;
          if (fast_in) begin
            acc_d[XLEN-1:0] = x1;
            state_d         = StFast;
          end else begin
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        a_d   = a_nx;
        b_d   = b_nx;
        acc_d = acc_nx;
        cnt_d = cnt_q + 7'd1;
        if (cnt_q == (word_q ? 7'd31 : 7'(XLEN - 1))) begin
          out_data_d = calc_res;
          state_d    = StDone;
        end
      end
      StFast: begin
        out_data_d = fast_res;
        state_d    = StDone;
      end
      StDone: begin
        if (out_valid_q && out_ready) state_d = StIdle;
        else                          out_valid_d = 1'b1;
      end
      default: state_d = StIdle;
    endcase

    if (flush) begin
      state_d     = StIdle;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      op_q        <= '0;
      word_q      <= 1'b0;
      neg_q       <= 1'b0;
      fdz_q       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      word_q      <= word_d;
      neg_q       <= neg_d;
      fdz_q       <= fdz_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed self-checking bench for mdu_iter at XLEN=64 with word ops enabled.
module tb_mdu_iter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_op = 3'b000;
  logic        in_word = 1'b0;
  logic [63:0] in_src1 = '0;
  logic [63:0] in_src2 = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_data;
  logic        busy;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clock = ~clock;

  mdu_iter #(.XLEN(64), .HAS_WORD(1'b1)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_word   (in_word),
    .in_src1   (in_src1),
    .in_src2   (in_src2),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  // Issue one request and count edges from accept until out_valid (999 on timeout).
  task automatic do_op(input logic [2:0] op, input logic w, input logic [63:0] a,
                       input logic [63:0] b, output int edges, output logic [63:0] data);
    in_op = op; in_word = w; in_src1 = a; in_src2 = b; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    edges = 0;
    while (!out_valid && edges < 200) begin
      @(posedge clock); #1;
      edges++;
    end
    if (!out_valid) edges = 999;
    data = out_data;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_chk++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 64'd0)
      $display("FAIL reset_state got v=%b b=%b d=%h exp v=0 b=0 d=0", out_valid, busy, out_data);
    else n_pass++;
    reset = 1'b1;
    @(posedge clock); #1;
    n_chk++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", in_ready);
    else n_pass++;
  endtask

  task automatic test_mul();
    int e; logic [63:0] d;
    do_op(3'b000, 1'b0, -64'sd3, 64'd7, e, d);
    n_chk++;
    if (d !== 64'hFFFF_FFFF_FFFF_FFEB) $display("FAIL mul_neg got %h exp FFFFFFFFFFFFFFEB", d);
    else n_pass++;
    n_chk++;
    if (e !== 65) $display("FAIL mul_latency got %0d exp 65", e);
    else n_pass++;
    release_out();
    do_op(3'b011, 1'b0, '1, '1, e, d);
    n_chk++;
    if (d !== 64'hFFFF_FFFF_FFFF_FFFE) $display("FAIL mulhu got %h exp FFFFFFFFFFFFFFFE", d);
    else n_pass++;
    release_out();
    do_op(3'b010, 1'b0, '1, 64'd2, e, d);
    n_chk++;
    if (d !== 64'hFFFF_FFFF_FFFF_FFFF) $display("FAIL mulhsu got %h exp FFFFFFFFFFFFFFFF", d);
    else n_pass++;
    release_out();
  endtask

  task automatic test_div();
    int e; logic [63:0] d;
    do_op(3'b100, 1'b0, -64'sd7, 64'd2, e, d);
    n_chk++;
    if (d !== 64'hFFFF_FFFF_FFFF_FFFD) $display("FAIL div_neg got %h exp FFFFFFFFFFFFFFFD", d);
    else n_pass++;
    release_out();
    do_op(3'b110, 1'b0, -64'sd7, 64'd2, e, d);
    n_chk++;
    if (d !== 64'hFFFF_FFFF_FFFF_FFFF) $display("FAIL rem_neg got %h exp FFFFFFFFFFFFFFFF", d);
    else n_pass++;
    release_out();
  endtask

  task automatic test_fast();
    int e; logic [63:0] d;
    do_op(3'b101, 1'b0, 64'd5, 64'd0, e, d);
    n_chk++;
    if (d !== 64'hFFFF_FFFF_FFFF_FFFF) $display("FAIL divu_zero got %h exp FFFFFFFFFFFFFFFF", d);
    else n_pass++;
    n_chk++;
    if (e !== 2) $display("FAIL fast_latency got %0d exp 2", e);
    else n_pass++;
    release_out();
    do_op(3'b111, 1'b0, 64'd5, 64'd0, e, d);
    n_chk++;
    if (d !== 64'd5) $display("FAIL remu_zero got %h exp 5", d);
    else n_pass++;
    release_out();
    do_op(3'b100, 1'b0, 64'h8000_0000_0000_0000, '1, e, d);
    n_chk++;
    if (d !== 64'h8000_0000_0000_0000) $display("FAIL div_ovf got %h exp 8000000000000000", d);
    else n_pass++;
    release_out();
    do_op(3'b110, 1'b0, 64'h8000_0000_0000_0000, '1, e, d);
    n_chk++;
    if (d !== 64'd0) $display("FAIL rem_ovf got %h exp 0", d);
    else n_pass++;
    release_out();
  endtask

  task automatic test_word();
    int e; logic [63:0] d;
    do_op(3'b100, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, e, d);
    n_chk++;
    if (d !== 64'hFFFF_FFFF_8000_0000) $display("FAIL divw_ovf got %h exp FFFFFFFF80000000", d);
    else n_pass++;
    release_out();
    do_op(3'b101, 1'b1, 64'h10, 64'h3, e, d);
    n_chk++;
    if (d !== 64'd5) $display("FAIL divuw got %h exp 5", d);
    else n_pass++;
    n_chk++;
    if (e !== 33) $display("FAIL divuw_latency got %0d exp 33", e);
    else n_pass++;
    release_out();
    do_op(3'b000, 1'b1, 64'h7FFF_FFFF, 64'd2, e, d);
    n_chk++;
    if (d !== 64'hFFFF_FFFF_FFFF_FFFE) $display("FAIL mulw got %h exp FFFFFFFFFFFFFFFE", d);
    else n_pass++;
    release_out();
  endtask

  task automatic test_back_to_back();
    int e; logic [63:0] d; logic stable;
    do_op(3'b000, 1'b0, 64'd6, 64'd7, e, d);
    stable = 1'b1;
    repeat (10) begin
      @(posedge clock); #1;
      if (out_valid !== 1'b1 || out_data !== 64'd42 || in_ready !== 1'b0) stable = 1'b0;
    end
    n_chk++;
    if (stable !== 1'b1 || d !== 64'd42)
      $display("FAIL done_hold got stable=%b d=%h exp stable=1 d=42", stable, d);
    else n_pass++;
    release_out();
    n_chk++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL done_release got rdy=%b v=%b exp rdy=1 v=0", in_ready, out_valid);
    else n_pass++;
    do_op(3'b100, 1'b0, 64'd100, -64'sd9, e, d);
    n_chk++;
    if (d !== 64'hFFFF_FFFF_FFFF_FFF5 || e !== 65)
      $display("FAIL second_req got d=%h e=%0d exp d=FFFFFFFFFFFFFFF5 e=65", d, e);
    else n_pass++;
    release_out();
  endtask

  task automatic test_flush();
    int e; logic [63:0] d; logic seen;
    in_op = 3'b101; in_word = 1'b0; in_src1 = 64'd100; in_src2 = 64'd7; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (19) begin @(posedge clock); #1; end
    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    n_chk++;
    if (busy !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL flush_calc got busy=%b rdy=%b exp busy=0 rdy=1", busy, in_ready);
    else n_pass++;
    seen = 1'b0;
    repeat (80) begin
      @(posedge clock); #1;
      if (out_valid) seen = 1'b1;
    end
    n_chk++;
    if (seen !== 1'b0) $display("FAIL flush_no_result got out_valid seen=%b exp 0", seen);
    else n_pass++;
    in_op = 3'b000; in_valid = 1'b1; flush = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0; flush = 1'b0;
    n_chk++;
    if (busy !== 1'b0) $display("FAIL flush_idle_accept got busy=%b exp 0", busy);
    else n_pass++;
    do_op(3'b000, 1'b0, 64'd3, 64'd5, e, d);
    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    n_chk++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL flush_done got v=%b rdy=%b exp v=0 rdy=1", out_valid, in_ready);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    int e; logic [63:0] d;
    in_op = 3'b000; in_word = 1'b0; in_src1 = 64'd3; in_src2 = 64'd3; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (10) begin @(posedge clock); #1; end
    #1 reset = 1'b0;
    #1;
    n_chk++;
    if (out_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL async_reset got v=%b busy=%b exp v=0 busy=0", out_valid, busy);
    else n_pass++;
    #4 reset = 1'b1;
    @(posedge clock); #1;
    do_op(3'b000, 1'b0, 64'd6, 64'd7, e, d);
    n_chk++;
    if (d !== 64'd42 || e !== 65)
      $display("FAIL post_reset_mul got d=%h e=%0d exp d=2a e=65", d, e);
    else n_pass++;
    release_out();
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_fast();
    test_word();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
